// File: rtl/fetch_ifid_stage.sv
// rtl/fetch_ifid_stage.sv - fetch stage owning the PC plus the IF/ID pipeline register
// Optional FETCH_PERF_CNT_EN adds saturating stall_cycles / bubble_cycles counters.
module fetch_ifid_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        STALL,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] instr_reg,
    output logic [15:0] pc_plus2_reg,
    output logic        valid_reg,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] bubble_cycles
`endif
);

    typedef enum logic {
        S_FETCH  = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic        halted_q;
    logic [15:0] pc_next;

    assign pc_next   = pc_q + 16'd2;
    assign imem_addr = pc_q;
    assign imem_rd   = (state_q == S_FETCH) & ~STALL & ~rst;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc2_d   = pc2_q;
        valid_d = valid_q;
        state_d = state_q;
        if (redirect) begin
            // Redirect overrides STALL: the in-flight fetch is wrong-path either way.
            pc_d    = redirect_pc & 16'hFFFE;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = S_FETCH;
        end else if (!STALL) begin
            if (state_q == S_HALTED || !imem_done) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end else begin
                instr_d = imem_data;
                pc2_d   = pc_next;
                valid_d = 1'b1;
                if (imem_data[15:11] == HALT_OPC) begin
                    state_d = S_HALTED;
                end else begin
                    pc_d = pc_next;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc2_q    <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc2_q    <= pc2_d;
            valid_q  <= valid_d;
            halted_q <= (state_d == S_HALTED);
        end
    end

    assign instr_reg    = instr_q;
    assign pc_plus2_reg = pc2_q;
    assign valid_reg    = valid_q;
    assign halted       = halted_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic        stall_inc, bubble_inc;

    // Only genuine memory-miss bubbles count; redirect squashes and HALTED NOPs do not.
    assign stall_inc  = STALL & ~redirect;
    assign bubble_inc = ~redirect & ~STALL & (state_q == S_FETCH) & ~imem_done;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_inc && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (bubble_inc && bubble_cnt_q != 16'hFFFF) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= 16'h0000;
            bubble_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign bubble_cycles = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// tb/tb_fetch_ifid_stage.sv - scoreboard testbench for fetch_ifid_stage
module tb_fetch_ifid_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        STALL = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_done = 1'b0;
    logic [15:0] instr_reg;
    logic [15:0] pc_plus2_reg;
    logic        valid_reg;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] bubble_cycles;
`endif

    fetch_ifid_stage dut (
        .clk          (clk),
        .rst          (rst),
        .STALL        (STALL),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_rd      (imem_rd),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .imem_done    (imem_done),
        .instr_reg    (instr_reg),
        .pc_plus2_reg (pc_plus2_reg),
        .valid_reg    (valid_reg),
        .halted       (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .bubble_cycles(bubble_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic        done;
        logic [15:0] data;
    } stim_t;

    typedef struct packed {
        logic        rd;
        logic [15:0] apre;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        valid;
        logic        halted;
        logic [15:0] apost;
    } obs_t;

    typedef struct packed {
        obs_t v;
        logic chk_pc2;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        rd_seen;
    logic [15:0] apre_seen;

    function automatic stim_t S(logic stall, logic redir, logic [15:0] rpc, logic done, logic [15:0] data);
        stim_t s;
        s.stall = stall; s.redir = redir; s.rpc = rpc; s.done = done; s.data = data;
        return s;
    endfunction

    function automatic exp_t E(logic rd, logic [15:0] apre, logic [15:0] instr, logic [15:0] pc2,
                               logic chk, logic valid, logic hlt, logic [15:0] apost);
        exp_t e;
        e.v.rd = rd; e.v.apre = apre; e.v.instr = instr; e.v.pc2 = chk ? pc2 : 16'h0;
        e.v.valid = valid; e.v.halted = hlt; e.v.apost = apost; e.chk_pc2 = chk;
        return e;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("rd=%b addr_pre=%h instr=%h pc2=%h valid=%b halted=%b addr_post=%h",
                         o.rd, o.apre, o.instr, o.pc2, o.valid, o.halted, o.apost);
    endfunction

    function automatic obs_t observe(logic chk);
        obs_t o;
        o.rd = rd_seen; o.apre = apre_seen; o.instr = instr_reg;
        o.pc2 = chk ? pc_plus2_reg : 16'h0;
        o.valid = valid_reg; o.halted = halted; o.apost = imem_addr;
        return o;
    endfunction

    // Called at a negedge: drive one cycle of inputs, sample combinational outputs, cross one edge.
    task automatic cyc(input stim_t s);
        STALL = s.stall; redirect = s.redir; redirect_pc = s.rpc;
        imem_done = s.done; imem_data = s.data;
        #1;
        rd_seen = imem_rd;
        apre_seen = imem_addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        STALL = 0; redirect = 0; redirect_pc = 0; imem_done = 0; imem_data = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        obs_t  got;
        do_reset();
        rst = 1;
        #1;
        n_cmp++;
        if (imem_rd !== 1'b0 || imem_addr !== 16'h0000 || instr_reg !== 16'h0800 ||
            pc_plus2_reg !== 16'h0000 || valid_reg !== 1'b0 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values got rd=%b addr=%h instr=%h pc2=%h valid=%b halted=%b want 0 0000 0800 0000 0 0",
                     imem_rd, imem_addr, instr_reg, pc_plus2_reg, valid_reg, halted);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (stall_cycles !== 16'd0 || bubble_cycles !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cycles, bubble_cycles);
        end
`endif
        @(negedge clk);
        rst = 0;
        st.push_back(S(0, 0, 16'h0, 1, 16'h4101)); ex.push_back(E(1, 16'h0000, 16'h4101, 16'h0002, 1, 1, 0, 16'h0002));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            cyc(st[i]);
            e = sb.pop_front();
            got = observe(e.chk_pc2);
            n_cmp++;
            if (got !== e.v) begin
                n_bad++;
                $display("FAIL reset_pre[%0d] got %s want %s", i, fmt(got), fmt(e.v));
            end
        end
        // Asynchronous reset asserted mid-stall, away from any clock edge.
        STALL = 1;
        #2 rst = 1;
        #1;
        n_cmp++;
        if (imem_rd !== 1'b0 || imem_addr !== 16'h0000 || instr_reg !== 16'h0800 ||
            valid_reg !== 1'b0 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async got rd=%b addr=%h instr=%h valid=%b halted=%b want 0 0000 0800 0 0",
                     imem_rd, imem_addr, instr_reg, valid_reg, halted);
        end
        @(negedge clk);
        STALL = 0;
        rst = 0;
    endtask

    task automatic test_fetch();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        obs_t  got;
        do_reset();
        st.push_back(S(0, 0, 16'h0, 1, 16'h4101)); ex.push_back(E(1, 16'h0000, 16'h4101, 16'h0002, 1, 1, 0, 16'h0002));
        st.push_back(S(0, 0, 16'h0, 1, 16'h4202)); ex.push_back(E(1, 16'h0002, 16'h4202, 16'h0004, 1, 1, 0, 16'h0004));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            cyc(st[i]);
            e = sb.pop_front();
            got = observe(e.chk_pc2);
            n_cmp++;
            if (got !== e.v) begin
                n_bad++;
                $display("FAIL fetch[%0d] got %s want %s", i, fmt(got), fmt(e.v));
            end
        end
    endtask

    task automatic test_stall();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        obs_t  got;
        do_reset();
        st.push_back(S(0, 0, 16'h0, 1, 16'h4101)); ex.push_back(E(1, 16'h0000, 16'h4101, 16'h0002, 1, 1, 0, 16'h0002));
        for (int k = 0; k < 3; k++) begin
            st.push_back(S(1, 0, 16'h0, 1, 16'h4202)); ex.push_back(E(0, 16'h0002, 16'h4101, 16'h0002, 1, 1, 0, 16'h0002));
        end
        st.push_back(S(0, 0, 16'h0, 1, 16'h4202)); ex.push_back(E(1, 16'h0002, 16'h4202, 16'h0004, 1, 1, 0, 16'h0004));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            cyc(st[i]);
            e = sb.pop_front();
            got = observe(e.chk_pc2);
            n_cmp++;
            if (got !== e.v) begin
                n_bad++;
                $display("FAIL stall[%0d] got %s want %s", i, fmt(got), fmt(e.v));
            end
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (stall_cycles !== 16'd3 || bubble_cycles !== 16'd0) begin
            n_bad++;
            $display("FAIL stall_counters got %0d/%0d want 3/0", stall_cycles, bubble_cycles);
        end
`endif
    endtask

    // Continues from test_stall's final state (PC 0x0004).
    task automatic test_redirect_stall();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        obs_t  got;
        st.push_back(S(1, 1, 16'h0040, 1, 16'h4303)); ex.push_back(E(0, 16'h0004, 16'h0800, 16'h0, 0, 0, 0, 16'h0040));
        st.push_back(S(0, 0, 16'h0000, 1, 16'h4303)); ex.push_back(E(1, 16'h0040, 16'h4303, 16'h0042, 1, 1, 0, 16'h0042));
        st.push_back(S(0, 1, 16'h0077, 1, 16'h4404)); ex.push_back(E(1, 16'h0042, 16'h0800, 16'h0, 0, 0, 0, 16'h0076));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            cyc(st[i]);
            e = sb.pop_front();
            got = observe(e.chk_pc2);
            n_cmp++;
            if (got !== e.v) begin
                n_bad++;
                $display("FAIL redirect[%0d] got %s want %s", i, fmt(got), fmt(e.v));
            end
        end
    endtask

    task automatic test_miss();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        obs_t  got;
        do_reset();
        st.push_back(S(0, 1, 16'h0011, 1, 16'h4505)); ex.push_back(E(1, 16'h0000, 16'h0800, 16'h0, 0, 0, 0, 16'h0010));
        st.push_back(S(0, 0, 16'h0000, 0, 16'h4505)); ex.push_back(E(1, 16'h0010, 16'h0800, 16'h0, 0, 0, 0, 16'h0010));
        st.push_back(S(0, 0, 16'h0000, 0, 16'h4505)); ex.push_back(E(1, 16'h0010, 16'h0800, 16'h0, 0, 0, 0, 16'h0010));
        st.push_back(S(0, 0, 16'h0000, 1, 16'h4505)); ex.push_back(E(1, 16'h0010, 16'h4505, 16'h0012, 1, 1, 0, 16'h0012));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            cyc(st[i]);
            e = sb.pop_front();
            got = observe(e.chk_pc2);
            n_cmp++;
            if (got !== e.v) begin
                n_bad++;
                $display("FAIL miss[%0d] got %s want %s", i, fmt(got), fmt(e.v));
            end
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (stall_cycles !== 16'd0 || bubble_cycles !== 16'd2) begin
            n_bad++;
            $display("FAIL miss_counters got %0d/%0d want 0/2", stall_cycles, bubble_cycles);
        end
`endif
    endtask

    task automatic test_halt();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        obs_t  got;
        do_reset();
        // HALT word in the redirect shadow is squashed.
        st.push_back(S(0, 1, 16'h0020, 1, 16'h0000)); ex.push_back(E(1, 16'h0000, 16'h0800, 16'h0, 0, 0, 0, 16'h0020));
        st.push_back(S(0, 0, 16'h0000, 1, 16'h07FF)); ex.push_back(E(1, 16'h0020, 16'h07FF, 16'h0022, 1, 1, 1, 16'h0020));
        st.push_back(S(1, 0, 16'h0000, 1, 16'h4444)); ex.push_back(E(0, 16'h0020, 16'h07FF, 16'h0022, 1, 1, 1, 16'h0020));
        st.push_back(S(0, 0, 16'h0000, 1, 16'h4444)); ex.push_back(E(0, 16'h0020, 16'h0800, 16'h0, 0, 0, 1, 16'h0020));
        st.push_back(S(0, 0, 16'h0000, 1, 16'h4444)); ex.push_back(E(0, 16'h0020, 16'h0800, 16'h0, 0, 0, 1, 16'h0020));
        st.push_back(S(0, 1, 16'h0030, 1, 16'h0000)); ex.push_back(E(0, 16'h0020, 16'h0800, 16'h0, 0, 0, 0, 16'h0030));
        st.push_back(S(0, 0, 16'h0000, 1, 16'h4606)); ex.push_back(E(1, 16'h0030, 16'h4606, 16'h0032, 1, 1, 0, 16'h0032));
        st.push_back(S(0, 0, 16'h0000, 1, 16'h0800)); ex.push_back(E(1, 16'h0032, 16'h0800, 16'h0034, 1, 1, 0, 16'h0034));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            cyc(st[i]);
            e = sb.pop_front();
            got = observe(e.chk_pc2);
            n_cmp++;
            if (got !== e.v) begin
                n_bad++;
                $display("FAIL halt[%0d] got %s want %s", i, fmt(got), fmt(e.v));
            end
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (stall_cycles !== 16'd1 || bubble_cycles !== 16'd0) begin
            n_bad++;
            $display("FAIL halt_counters got %0d/%0d want 1/0", stall_cycles, bubble_cycles);
        end
`endif
    endtask

    task automatic test_wrap();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        obs_t  got;
        do_reset();
        st.push_back(S(0, 1, 16'hFFFF, 1, 16'h4707)); ex.push_back(E(1, 16'h0000, 16'h0800, 16'h0, 0, 0, 0, 16'hFFFE));
        st.push_back(S(0, 0, 16'h0000, 1, 16'h4707)); ex.push_back(E(1, 16'hFFFE, 16'h4707, 16'h0000, 1, 1, 0, 16'h0000));
        st.push_back(S(0, 0, 16'h0000, 1, 16'h4808)); ex.push_back(E(1, 16'h0000, 16'h4808, 16'h0002, 1, 1, 0, 16'h0002));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            cyc(st[i]);
            e = sb.pop_front();
            got = observe(e.chk_pc2);
            n_cmp++;
            if (got !== e.v) begin
                n_bad++;
                $display("FAIL wrap[%0d] got %s want %s", i, fmt(got), fmt(e.v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_stall();
        test_miss();
        test_halt();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
